sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL take parameter DATA_LEN, default 8, as the data word width in bits (1..64).
REQ-002 The block SHALL take parameter FIFO_LEN, default 16, as the entry count; it must be a power of 2 in the range 2..256.
REQ-003 The block SHALL take parameter AF_LEVEL, default FIFO_LEN-2, as the almost-full threshold in entries.
REQ-004 The block SHALL take parameter AE_LEVEL, default 2, as the almost-empty threshold in entries.
REQ-005 The block SHALL take parameter FWFT, default 0, as the read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL have these ports, in order:
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous flush.
- i_write  in  1  write request.
- i_data  in  DATA_LEN  write data.
- i_read  in  1  read request.
- o_data  out  DATA_LEN  read data.
- o_empty_n  out  1  high when count > 0.
- o_full  out  1  high when count == FIFO_LEN.
- o_almost_full  out  1  high when count >= AF_LEVEL.
- o_almost_empty  out  1  high when count <= AE_LEVEL.
- o_count  out  clog2(FIFO_LEN)+1  current fill level.
- o_write_error  out  1  one-cycle pulse on a rejected write.
- o_read_error  out  1  one-cycle pulse on a rejected read.

Function
REQ-007 Storage SHALL hold FIFO_LEN entries, all usable; pointers SHALL be clog2(FIFO_LEN)+1 bits and wrap modulo 2*FIFO_LEN, with full/empty distinguished by the MSB.
REQ-008 A write SHALL be accepted when i_write=1 and (count < FIFO_LEN, or i_read is accepted in the same cycle); the accepted write stores i_data at the write pointer and increments that pointer.
REQ-009 A read SHALL be accepted when i_read=1 and count > 0; the accepted read increments the read pointer.
REQ-010 A read issued when count == 0 SHALL be rejected even if a write occurs in the same cycle (no bypass); the written word is stored.
REQ-011 With simultaneous accepted read and write, o_count SHALL be unchanged, including when count == FIFO_LEN.
REQ-012 o_count SHALL be a register updated each edge by +1 (write only), -1 (read only) or 0; all status flags SHALL be decoded from the registered o_count, so they change the cycle after the request edge.
REQ-013 When FWFT=0, o_data SHALL register the head word on the edge that accepts a read, and SHALL hold that value until the next accepted read, clear, or reset.
REQ-014 When FWFT=1, o_data SHALL present the head entry combinationally whenever o_empty_n=1, and an accepted read SHALL advance it to the next entry; o_data is unspecified while o_empty_n=0.
REQ-015 On a rejected write or rejected read, the matching error output SHALL be 1 for exactly the following cycle, with no change to pointers, count, or memory.
REQ-016 An error output SHALL be 0 in any cycle after a cycle with no rejected request of that type.
REQ-017 i_clear SHALL override i_read and i_write, and SHALL on the same edge:
- zero both pointers and o_count;
- zero the registered o_data;
- zero both error outputs.
REQ-018 Memory contents SHALL NOT be reset or cleared.

Reset
REQ-019 While i_reset_n=0, the block SHALL asynchronously force:
- pointers, o_count and registered o_data to 0;
- o_empty_n=0, o_full=0, o_write_error=0, o_read_error=0;
- o_almost_empty=1;
- o_almost_full=(AF_LEVEL==0).
REQ-020 Reset assertion mid-transfer SHALL discard all contents; the first accepted write after deassertion SHALL land at entry 0.

Verification
REQ-021 For all scenarios, use FIFO_LEN=4, DATA_LEN=8, AF_LEVEL=3, AE_LEVEL=1, FWFT=0 unless stated; the bench SHALL cover:
- Write A1,A2,A3,A4 on consecutive cycles -> o_count 1,2,3,4; o_almost_full rises after the 3rd write; o_full=1 after the 4th; a 5th write gives o_write_error=1 for one cycle with count staying 4.
- Full FIFO, read+write B5 in one cycle -> count stays 4, o_data=A1 next cycle; reading 4 more returns A2,A3,A4,B5.
- Empty FIFO, read -> o_read_error=1 for one cycle, o_data holds its prior value; read+write C1 together -> read_error=1, count=1.
- FWFT=1: write D1 -> o_data=D1 with o_empty_n=1 one cycle later, before any read; read -> o_data=D2 if present.
- Pointer wrap: run 10 write/read pairs through FIFO_LEN=4 -> data order preserved, count never exceeds 4.
- i_clear at count 3 with i_write=1 -> count=0, o_empty_n=0, write ignored; i_reset_n pulsed low mid-stream -> all outputs at reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered or first-word-fall-through read port
module sync_fifo #(
  parameter int DATA_LEN = 8,
  parameter int FIFO_LEN = 16,
  parameter int AF_LEVEL = FIFO_LEN - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_clear,
  input  logic                      i_write,
  input  logic [DATA_LEN-1:0]       i_data,
  input  logic                      i_read,
  output logic [DATA_LEN-1:0]       o_data,
  output logic                      o_empty_n,
  output logic                      o_full,
  output logic                      o_almost_full,
  output logic                      o_almost_empty,
  output logic [$clog2(FIFO_LEN):0] o_count,
  output logic                      o_write_error,
  output logic                      o_read_error
);

  localparam int AW = $clog2(FIFO_LEN);
  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_LEN);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);

  logic [DATA_LEN-1:0] mem_q [FIFO_LEN];
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                wr_err_q, wr_err_d;
  logic                rd_err_q, rd_err_d;
  logic                rd_ok, wr_ok, mem_we;

  // A read frees a slot in the same cycle, so a full FIFO still takes a paired write.
  always_comb begin
    rd_ok    = i_read && (count_q != '0);
    wr_ok    = i_write && ((count_q != FULL_CNT) || rd_ok);
    mem_we   = wr_ok && !i_clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_err_d = 1'b0;
    rd_err_d = 1'b0;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
      wr_err_d = i_write && !wr_ok;
      rd_err_d = i_read && !rd_ok;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Storage is intentionally never reset; pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_LEN-1:0] data_q, data_d;

      always_comb begin
        data_d = data_q;
        if (i_clear)    data_d = '0;
        else if (rd_ok) data_d = mem_q[rd_ptr_q[AW-1:0]];
      end

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) data_q <= '0;
        else            data_q <= data_d;
      end

      assign o_data = data_q;
    end else begin : g_fwft_read
      assign o_data = mem_q[rd_ptr_q[AW-1:0]];
    end
  endgenerate

  assign o_count        = count_q;
  assign o_empty_n      = (count_q != '0);
  assign o_full         = (count_q == FULL_CNT);
  assign o_almost_full  = (count_q >= AF_CNT);
  assign o_almost_empty = (count_q <= AE_CNT);
  assign o_write_error  = wr_err_q;
  assign o_read_error   = rd_err_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo in registered and FWFT read modes
module tb_sync_fifo;

  localparam int DL = 8;
  localparam int FL = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_clear = 1'b0;
  logic          i_write = 1'b0;
  logic          i_read = 1'b0;
  logic [DL-1:0] i_data = '0;

  logic [DL-1:0] d0_data, d1_data;
  logic          d0_empty_n, d0_full, d0_af, d0_ae, d0_werr, d0_rerr;
  logic          d1_empty_n, d1_full, d1_af, d1_ae, d1_werr, d1_rerr;
  logic [2:0]    d0_count, d1_count;

  sync_fifo #(.DATA_LEN(DL), .FIFO_LEN(FL), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clear(i_clear), .i_write(i_write),
    .i_data(i_data), .i_read(i_read), .o_data(d0_data), .o_empty_n(d0_empty_n),
    .o_full(d0_full), .o_almost_full(d0_af), .o_almost_empty(d0_ae), .o_count(d0_count),
    .o_write_error(d0_werr), .o_read_error(d0_rerr)
  );

  sync_fifo #(.DATA_LEN(DL), .FIFO_LEN(FL), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut1 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clear(i_clear), .i_write(i_write),
    .i_data(i_data), .i_read(i_read), .o_data(d1_data), .o_empty_n(d1_empty_n),
    .o_full(d1_full), .o_almost_full(d1_af), .o_almost_empty(d1_ae), .o_count(d1_count),
    .o_write_error(d1_werr), .o_read_error(d1_rerr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int            cnt;
    logic [DL-1:0] data;
    bit            werr;
    bit            rerr;
    logic [DL-1:0] head;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DL-1:0] model_q[$];
  logic [DL-1:0] last_data = '0;
  logic [5:0]    mon_flags;
  int            n_pass = 0;
  int            n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, expv, $time);
  endtask

  // Reference model: a plain queue whose size is the fill level.
  task automatic cycle(input bit w, input bit r, input logic [DL-1:0] d, input bit c);
    bit   ra, wa;
    exp_t e;
    i_write = w; i_read = r; i_data = d; i_clear = c;
    @(posedge i_clk);
    e.werr = 1'b0;
    e.rerr = 1'b0;
    if (c) begin
      model_q.delete();
      last_data = '0;
    end else begin
      ra = r && (model_q.size() > 0);
      wa = w && ((model_q.size() < FL) || ra);
      if (ra) last_data = model_q.pop_front();
      if (wa) model_q.push_back(d);
      e.werr = w && !wa;
      e.rerr = r && !ra;
    end
    e.cnt  = model_q.size();
    e.data = last_data;
    e.head = (model_q.size() > 0) ? model_q[0] : '0;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, d0_count, 0);
    chk({tag, "_data"}, d0_data, 0);
    chk({tag, "_empty_n"}, d0_empty_n, 0);
    chk({tag, "_full"}, d0_full, 0);
    chk({tag, "_almost_full"}, d0_af, (AF == 0));
    chk({tag, "_almost_empty"}, d0_ae, 1);
    chk({tag, "_write_error"}, d0_werr, 0);
    chk({tag, "_read_error"}, d0_rerr, 0);
    chk({tag, "_fwft_count"}, d1_count, 0);
    chk({tag, "_fwft_flags"}, {d1_empty_n, d1_full, d1_af, d1_ae, d1_werr, d1_rerr},
        {1'b0, 1'b0, (AF == 0), 1'b1, 1'b0, 1'b0});
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    #1;
    i_write = 1'b0; i_read = 1'b0; i_clear = 1'b0;
    i_reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    model_q.delete();
    last_data = '0;
    repeat (2) @(negedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_flags = {mon_e.cnt > 0, mon_e.cnt == FL, mon_e.cnt >= AF, mon_e.cnt <= AE,
                   mon_e.werr, mon_e.rerr};
      chk("count", d0_count, mon_e.cnt);
      chk("data", d0_data, mon_e.data);
      chk("empty_n", d0_empty_n, mon_flags[5]);
      chk("full", d0_full, mon_flags[4]);
      chk("almost_full", d0_af, mon_flags[3]);
      chk("almost_empty", d0_ae, mon_flags[2]);
      chk("write_error", d0_werr, mon_flags[1]);
      chk("read_error", d0_rerr, mon_flags[0]);
      chk("fwft_count", d1_count, mon_e.cnt);
      chk("fwft_flags", {d1_empty_n, d1_full, d1_af, d1_ae, d1_werr, d1_rerr}, mon_flags);
      if (mon_e.cnt > 0) chk("fwft_data", d1_data, mon_e.head);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pw;
    #12;
    chk_reset("rst");
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b1;

    for (int i = 0; i < 4; i++) cycle(1, 0, DL'(8'hA1 + i), 0);
    cycle(1, 0, 8'hA5, 0);
    cycle(0, 0, 8'h00, 0);

    cycle(1, 1, 8'hB5, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h00, 0);

    cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    cycle(1, 1, 8'hC1, 0);
    cycle(0, 0, 8'h00, 0);

    cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'hD1, 0);
    cycle(0, 0, 8'h00, 0);
    cycle(1, 0, 8'hD2, 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 1, 8'h00, 0);

    cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'h0F, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, DL'(8'h10 + i), 0);
      cycle(0, 1, 8'h00, 0);
    end

    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, DL'(8'hE1 + i), 0);
    cycle(1, 0, 8'hEE, 1);
    cycle(0, 0, 8'h00, 0);

    cycle(1, 0, 8'h31, 0);
    cycle(1, 0, 8'h32, 0);
    pulse_reset();
    cycle(1, 0, 8'h5A, 0);
    cycle(0, 0, 8'h00, 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);

    for (int i = 0; i < 400; i++) begin
      pw = (i % 100 < 50) ? 70 : 30;
      cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 50,
            DL'($urandom), $urandom_range(0, 39) == 0);
    end
    cycle(0, 0, 8'h00, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge i_clk);
    #1;
    if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
